// File: rtl/key_vault.sv
// Multi-slot secret-key store: one-cycle key release, per-slot use limits,
// and chunked zeroization of a slot (or of every slot) after use, on request or on reset.
module key_vault #(
  parameter int KEY_W     = 128,
  parameter int SLOTS     = 4,
  parameter int SCRUB_W   = 32,
  parameter int USE_LIMIT = 1,
  localparam int SW       = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             load_req,
  input  logic [SW-1:0]    load_slot,
  input  logic [KEY_W-1:0] load_key,
  input  logic             use_req,
  input  logic [SW-1:0]    use_slot,
  input  logic             zero_req,
  input  logic             zero_all,
  input  logic [SW-1:0]    zero_slot,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic [SLOTS-1:0] slot_valid,
  output logic             err,
  output logic             busy
);

  localparam int CHUNKS = KEY_W / SCRUB_W;
  localparam int CHW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int CW     = (USE_LIMIT < 2) ? 1 : $clog2(USE_LIMIT + 1);
  localparam int LIM_M1 = (USE_LIMIT == 0) ? 0 : USE_LIMIT - 1;
  // With no limit the counter simply saturates at all-ones and never triggers a scrub.
  localparam logic [CW-1:0] CNT_MAX = (USE_LIMIT == 0) ? {CW{1'b1}} : CW'(USE_LIMIT);

  typedef enum logic [0:0] {ST_IDLE, ST_SCRUB} state_e;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q [SLOTS];
  logic [KEY_W-1:0] key_d [SLOTS];
  logic [CW-1:0]    cnt_q [SLOTS];
  logic [CW-1:0]    cnt_d [SLOTS];
  logic [SLOTS-1:0] slot_valid_q, slot_valid_d;
  logic [SW-1:0]    scrub_slot_q, scrub_slot_d;
  logic [CHW-1:0]   chunk_q, chunk_d;
  logic             scrub_all_q, scrub_all_d;
  logic             auto_pend_q, auto_pend_d;
  logic [SW-1:0]    auto_slot_q, auto_slot_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic             key_valid_q, key_valid_d;
  logic             err_q, err_d;

  // NOTE: every variable gets a default before any branch so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    slot_valid_d = slot_valid_q;
    scrub_slot_d = scrub_slot_q;
    chunk_d      = chunk_q;
    scrub_all_d  = scrub_all_q;
    auto_pend_d  = auto_pend_q;
    auto_slot_d  = auto_slot_q;
    key_out_d    = '0;
    key_valid_d  = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A spent slot is scrubbed the cycle after its last release; requests then are dropped.
        if (auto_pend_q) begin
          state_d                   = ST_SCRUB;
          scrub_slot_d              = auto_slot_q;
          scrub_all_d               = 1'b0;
          chunk_d                   = '0;
          slot_valid_d[auto_slot_q] = 1'b0;
          auto_pend_d               = 1'b0;
        end else if (zero_req) begin
          state_d     = ST_SCRUB;
          scrub_all_d = zero_all;
          chunk_d     = '0;
          if (zero_all) begin
            scrub_slot_d = '0;
            slot_valid_d = '0;
          end else begin
            scrub_slot_d            = zero_slot;
            slot_valid_d[zero_slot] = 1'b0;
          end
        end else if (load_req) begin
          if (slot_valid_q[load_slot]) begin
            err_d = 1'b1;
          end else begin
            key_d[load_slot]        = load_key;
            slot_valid_d[load_slot] = 1'b1;
            cnt_d[load_slot]        = '0;
          end
        end else if (use_req) begin
          if (slot_valid_q[use_slot]) begin
            key_valid_d = 1'b1;
            key_out_d   = key_q[use_slot];
            if (cnt_q[use_slot] != CNT_MAX) cnt_d[use_slot] = cnt_q[use_slot] + CW'(1);
            if ((USE_LIMIT != 0) && (cnt_q[use_slot] == CW'(LIM_M1))) begin
              auto_pend_d = 1'b1;
              auto_slot_d = use_slot;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_SCRUB: begin
        key_d[scrub_slot_q][int'(chunk_q) * SCRUB_W +: SCRUB_W] = '0;
        if (chunk_q == CHW'(CHUNKS - 1)) begin
          cnt_d[scrub_slot_q] = '0;
          chunk_d             = '0;
          if (scrub_all_q && (scrub_slot_q != SW'(SLOTS - 1))) begin
            scrub_slot_d = scrub_slot_q + SW'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          chunk_d = chunk_q + CHW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: key storage is reset explicitly, because reset must leave no key material behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < SLOTS; i++) begin
        key_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      slot_valid_q <= '0;
      scrub_slot_q <= '0;
      chunk_q      <= '0;
      scrub_all_q  <= 1'b0;
      auto_pend_q  <= 1'b0;
      auto_slot_q  <= '0;
      key_out_q    <= '0;
      key_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      slot_valid_q <= slot_valid_d;
      scrub_slot_q <= scrub_slot_d;
      chunk_q      <= chunk_d;
      scrub_all_q  <= scrub_all_d;
      auto_pend_q  <= auto_pend_d;
      auto_slot_q  <= auto_slot_d;
      key_out_q    <= key_out_d;
      key_valid_q  <= key_valid_d;
      err_q        <= err_d;
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign busy       = ~ready;
  assign key_out    = key_out_q;
  assign key_valid  = key_valid_q;
  assign slot_valid = slot_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_key_vault.sv
// Directed bench for key_vault (USE_LIMIT=2): a one-cycle vector table plus
// a hand-written reset-during-scrub sequence.
module tb_key_vault;

  localparam int KEY_W = 128;
  localparam int SLOTS = 4;

  localparam logic [KEY_W-1:0] K0 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [KEY_W-1:0] K1 = 128'hdeadbeefcafef00d0badc0de12345678;
  localparam logic [KEY_W-1:0] K2 = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [KEY_W-1:0] K3 = 128'hffeeddccbbaa99887766554433221100;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready, busy, key_valid, err;
  logic             load_req, use_req, zero_req, zero_all;
  logic [1:0]       load_slot, use_slot, zero_slot;
  logic [KEY_W-1:0] load_key, key_out;
  logic [SLOTS-1:0] slot_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_vault #(.KEY_W(KEY_W), .SLOTS(SLOTS), .SCRUB_W(32), .USE_LIMIT(2)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .load_req(load_req), .load_slot(load_slot), .load_key(load_key),
    .use_req(use_req), .use_slot(use_slot),
    .zero_req(zero_req), .zero_all(zero_all), .zero_slot(zero_slot),
    .key_out(key_out), .key_valid(key_valid), .slot_valid(slot_valid),
    .err(err), .busy(busy)
  );

  typedef struct {
    logic ld; logic [1:0] ls; logic [KEY_W-1:0] lk;
    logic ur; logic [1:0] us;
    logic zr; logic za; logic [1:0] zs;
    logic kv; logic [KEY_W-1:0] ko; logic [SLOTS-1:0] sv; logic er; logic bz;
    logic pr; logic [1:0] ps; logic [KEY_W-1:0] pv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic ld, input logic [1:0] ls, input logic [KEY_W-1:0] lk,
    input logic ur, input logic [1:0] us,
    input logic zr, input logic za, input logic [1:0] zs,
    input logic kv, input logic [KEY_W-1:0] ko, input logic [SLOTS-1:0] sv,
    input logic er, input logic bz,
    input logic pr, input logic [1:0] ps, input logic [KEY_W-1:0] pv);
    vec_t v;
    v.ld = ld; v.ls = ls; v.lk = lk; v.ur = ur; v.us = us;
    v.zr = zr; v.za = za; v.zs = zs;
    v.kv = kv; v.ko = ko; v.sv = sv; v.er = er; v.bz = bz;
    v.pr = pr; v.ps = ps; v.pv = pv;
    return v;
  endfunction

  task automatic check(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [1:0] ls, input logic [KEY_W-1:0] lk,
                       input logic ur, input logic [1:0] us,
                       input logic zr, input logic za, input logic [1:0] zs);
    load_req = ld; load_slot = ls; load_key = lk;
    use_req = ur; use_slot = us;
    zero_req = zr; zero_all = za; zero_slot = zs;
  endtask

  function automatic logic [KEY_W-1:0] store(input int s);
    return dut.key_q[s];
  endfunction

  initial begin
    rst = 1'b1;
    drive(0, 0, '0, 0, 0, 0, 0, 0);

    // Expectations in each row describe the cycle after that row's inputs.
    //                 ld ls lk  ur us zr za zs   kv ko  sv       er bz  pr ps pv
    tbl.push_back(mk(1, 2, K2, 0, 0, 0, 0, 0,   0, '0, 4'b0100, 0, 0,  0, 0, '0));
    tbl.push_back(mk(0, 0, '0, 1, 2, 0, 0, 0,   1, K2, 4'b0100, 0, 0,  0, 0, '0));
    tbl.push_back(mk(0, 0, '0, 0, 0, 0, 0, 0,   0, '0, 4'b0100, 0, 0,  0, 0, '0));
    tbl.push_back(mk(0, 0, '0, 1, 2, 0, 0, 0,   1, K2, 4'b0100, 0, 0,  0, 0, '0));
    tbl.push_back(mk(0, 0, '0, 0, 0, 0, 0, 0,   0, '0, 4'b0000, 0, 1,  0, 0, '0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, '0, 0, 0, 0, 0, 0, 0, '0, 4'b0000, 0, 1,  0, 0, '0));
    tbl.push_back(mk(0, 0, '0, 0, 0, 0, 0, 0,   0, '0, 4'b0000, 0, 0,  1, 2, '0));
    // Overwrite refused, empty-slot use refused.
    tbl.push_back(mk(1, 1, K1, 0, 0, 0, 0, 0,   0, '0, 4'b0010, 0, 0,  0, 0, '0));
    tbl.push_back(mk(1, 1, K3, 0, 0, 0, 0, 0,   0, '0, 4'b0010, 1, 0,  0, 0, '0));
    tbl.push_back(mk(0, 0, '0, 0, 0, 0, 0, 0,   0, '0, 4'b0010, 0, 0,  1, 1, K1));
    tbl.push_back(mk(0, 0, '0, 1, 3, 0, 0, 0,   0, '0, 4'b0010, 1, 0,  0, 0, '0));
    tbl.push_back(mk(0, 0, '0, 1, 1, 0, 0, 0,   1, K1, 4'b0010, 0, 0,  0, 0, '0));
    // Fill all slots, then scrub everything: 16 busy cycles with loads ignored.
    tbl.push_back(mk(1, 0, K0, 0, 0, 0, 0, 0,   0, '0, 4'b0011, 0, 0,  0, 0, '0));
    tbl.push_back(mk(1, 2, K2, 0, 0, 0, 0, 0,   0, '0, 4'b0111, 0, 0,  0, 0, '0));
    tbl.push_back(mk(1, 3, K3, 0, 0, 0, 0, 0,   0, '0, 4'b1111, 0, 0,  1, 3, K3));
    tbl.push_back(mk(0, 0, '0, 0, 0, 1, 1, 2,   0, '0, 4'b0000, 0, 1,  0, 0, '0));
    for (int i = 0; i < 15; i++)
      tbl.push_back(mk(1, 0, K0, 0, 0, 0, 0, 0, 0, '0, 4'b0000, 0, 1,  0, 0, '0));
    tbl.push_back(mk(0, 0, '0, 0, 0, 0, 0, 0,   0, '0, 4'b0000, 0, 0,  1, 3, '0));
    // Scrub beats a same-cycle use of the same slot.
    tbl.push_back(mk(1, 0, K0, 0, 0, 0, 0, 0,   0, '0, 4'b0001, 0, 0,  0, 0, '0));
    tbl.push_back(mk(0, 0, '0, 1, 0, 1, 0, 0,   0, '0, 4'b0000, 0, 1,  0, 0, '0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, '0, 0, 0, 0, 0, 0, 0, '0, 4'b0000, 0, 1,  0, 0, '0));
    tbl.push_back(mk(0, 0, '0, 0, 0, 0, 0, 0,   0, '0, 4'b0000, 0, 0,  1, 0, '0));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset ready", KEY_W'(ready), KEY_W'(1));
    check("reset busy", KEY_W'(busy), '0);
    check("reset key_out", key_out, '0);
    check("reset key_valid", KEY_W'(key_valid), '0);
    check("reset slot_valid", KEY_W'(slot_valid), '0);
    check("reset err", KEY_W'(err), '0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ld, tbl[i].ls, tbl[i].lk, tbl[i].ur, tbl[i].us, tbl[i].zr, tbl[i].za, tbl[i].zs);
      @(negedge clk);
      check($sformatf("v%0d key_valid", i), KEY_W'(key_valid), KEY_W'(tbl[i].kv));
      check($sformatf("v%0d key_out", i), key_out, tbl[i].ko);
      check($sformatf("v%0d slot_valid", i), KEY_W'(slot_valid), KEY_W'(tbl[i].sv));
      check($sformatf("v%0d err", i), KEY_W'(err), KEY_W'(tbl[i].er));
      check($sformatf("v%0d busy", i), KEY_W'(busy), KEY_W'(tbl[i].bz));
      check($sformatf("v%0d ready", i), KEY_W'(ready), KEY_W'(!tbl[i].bz));
      if (tbl[i].pr) check($sformatf("v%0d store[%0d]", i, tbl[i].ps), store(int'(tbl[i].ps)), tbl[i].pv);
    end

    // Reset two cycles into a scrub of slot 1 while slot 0 still holds a key.
    drive(1, 0, K0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, K1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, '0, 0, 0, 1, 0, 1);
    @(negedge clk);
    check("rst-scrub busy1", KEY_W'(busy), KEY_W'(1));
    drive(0, 0, '0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst-scrub busy2", KEY_W'(busy), KEY_W'(1));
    check("rst-scrub slot0 held", store(0), K0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst-scrub ready", KEY_W'(ready), KEY_W'(1));
    check("rst-scrub slot_valid", KEY_W'(slot_valid), '0);
    for (int s = 0; s < SLOTS; s++) check($sformatf("rst-scrub store[%0d]", s), store(s), '0);
    @(negedge clk);
    check("post-rst busy", KEY_W'(busy), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_vault.md
# key_vault

Multi-slot secret-key store with enforced use limits and multi-cycle zeroization, replacing the single-register key holder in the crypto datapath. It holds up to SLOTS keys, releases a key to the cipher core as a one-cycle pulse on request, and scrubs each slot after its use budget is spent, on explicit request, or on reset. Key material is never visible on `key_out` outside the single valid cycle.

## Interface
- KEY_W, 128, key width in bits; must be a multiple of SCRUB_W
- SLOTS, 4, number of key slots (≥2); SW = clog2(SLOTS)
- SCRUB_W, 32, bits cleared per scrub cycle
- USE_LIMIT, 1, releases allowed per load before auto-scrub; 0 means unlimited
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high in IDLE; requests are sampled only when ready=1
- load_req  in  1  load request
- load_slot  in  SW  target slot
- load_key  in  KEY_W  key to store
- use_req  in  1  key release request
- use_slot  in  SW  slot to release
- zero_req  in  1  scrub request
- zero_all  in  1  with zero_req: scrub every slot, ignore zero_slot
- zero_slot  in  SW  slot to scrub
- key_out  out  KEY_W  released key; all-zero whenever key_valid=0
- key_valid  out  1  one-cycle release strobe
- slot_valid  out  SLOTS  per-slot "holds a key" flags
- err  out  1  one-cycle strobe for a rejected request
- busy  out  1  scrub in progress (equals ~ready)

## Operation
- Storage: SLOTS × KEY_W registers plus a per-slot use counter wide enough for USE_LIMIT.
- FSM states: IDLE, SCRUB. SCRUB visits the target slot(s) one chunk at a time, SCRUB_W bits per cycle, from chunk 0 up.
- IDLE request priority in a cycle: zero_req > load_req > use_req. Only the highest request is acted on. Lower requests are dropped without err. The source must re-issue them.
- Load: if slot_valid[load_slot]=0, write the key, set slot_valid, clear the use counter. If the slot is already valid, reject with err; overwrite is never allowed.
- Use: if the slot is valid, the next cycle drives key_out=key and key_valid=1, then increments the counter. If the counter reaches USE_LIMIT (USE_LIMIT≠0), the FSM enters SCRUB for that slot in the cycle after the release. Use of an empty slot: err, key_out stays 0.
- Zeroize: clear slot_valid for the target slot(s) in the first SCRUB cycle. Clear one chunk per cycle; counters are cleared at slot end. zero_all scrubs slots 0..SLOTS-1 in order. zero_req on an empty slot still performs the full scrub, with no err.
- Reset: all storage, counters, slot_valid, key_out, key_valid and err go to 0 in one cycle. ready=1 after reset. Reset during SCRUB aborts it; storage is still fully zero because reset clears everything.
- Counters saturate; they never wrap.

## Timing
- Reset values: ready=1, busy=0, key_out=0, key_valid=0, slot_valid=0, err=0.
- Load: request in cycle N; slot_valid updates at N+1.
- Use: request in cycle N; key_valid and key_out in N+1; key_out returns to 0 at N+2. The next use is accepted at N+1 if no auto-scrub is triggered.
- Auto-scrub: busy rises at N+2 and lasts KEY_W/SCRUB_W cycles (4 at defaults). ready returns the cycle after the last chunk.
- Explicit scrub: zero_req in N; busy from N+1 for C=KEY_W/SCRUB_W cycles, or SLOTS×C cycles with zero_all.
- err: one-cycle strobe at N+1 for a rejected request in N.
- Requests while ready=0 are ignored: no err, no state change.

## Test plan
- Reset then load slot 2 with 0x0123…CDEF -> slot_valid=4'b0100 next cycle; key_out remains 0.
- USE_LIMIT=2: use slot 2 twice -> two one-cycle key_valid pulses carrying the key. After the second, busy for 4 cycles, then slot_valid[2]=0 and an internal storage probe reads 0.
- Load an occupied slot 1 -> err pulse, stored key unchanged. Use empty slot 3 -> err, key_valid=0, key_out=0.
- Load slots 0..3, zero_req with zero_all=1 -> slot_valid=0 at the first SCRUB cycle, busy for 16 cycles. load_req during busy is ignored (no err).
- Same-cycle zero_req(slot 0) + use_req(slot 0) -> scrub wins, no key_valid, no err.
- Assert rst two cycles into a scrub of slot 1 while slot 0 is loaded -> next cycle all storage=0, slot_valid=0, ready=1.
